// File: rtl/best_mv_tracker.sv
// best_mv_tracker
// Takes the per-column minimum SAD from the 16-row compare tree, one column per
// accepted beat. It keeps the running minimum over a macroblock search and
// presents the block's best SAD and motion vector through a valid/ready output.
// A block closes on in_last, or after NUM_COLS beats, whichever comes first.
// Optional build macro: MV_SIGNED_EN. When it is defined, mv_x/mv_y are
// reported as two's-complement offsets from the centre of the search window.
// When it is undefined, they are the raw column/row indices.

module best_mv_tracker #(
   parameter int SAD_W    = 14,
   parameter int MVY_W    = 4,
   parameter int MVX_W    = 4,
   parameter int NUM_COLS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SAD_W-1:0] sad_cmp,
   input  logic [MVY_W-1:0] motion_vec_y,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SAD_W-1:0] best_sad,
   output logic [MVX_W-1:0] mv_x,
   output logic [MVY_W-1:0] mv_y,
   output logic [MVX_W-1:0] col_count
);

   // Block states: waiting for a first beat, accumulating columns, or
   // holding a finished result until downstream takes it.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [MVX_W-1:0] COL_LAST = MVX_W'(NUM_COLS - 1);
   localparam logic [MVX_W-1:0] COL_ONE  = MVX_W'(1);

   // Centre offsets, used only when signed motion vectors are enabled.
   localparam logic [MVX_W-1:0] X_CENTRE = MVX_W'(NUM_COLS / 2);
   localparam logic [MVY_W-1:0] Y_CENTRE = MVY_W'(2 ** (MVY_W - 1));

   logic [1:0]       state_q,     state_d;
   logic [MVX_W-1:0] col_q,       col_d;
   logic [SAD_W-1:0] run_sad_q,   run_sad_d;
   logic [MVX_W-1:0] run_x_q,     run_x_d;
   logic [MVY_W-1:0] run_y_q,     run_y_d;
   logic [SAD_W-1:0] best_sad_q,  best_sad_d;
   logic [MVX_W-1:0] mv_x_q,      mv_x_d;
   logic [MVY_W-1:0] mv_y_q,      mv_y_d;
   logic [MVX_W-1:0] col_count_q, col_count_d;

   logic             beatAccept;
   logic             firstBeat;
   logic             takeBeat;
   logic             closeBeat;
   logic             outXfer;
   logic [SAD_W-1:0] candSad;
   logic [MVX_W-1:0] candX;
   logic [MVY_W-1:0] candY;
   logic [MVX_W-1:0] encX;
   logic [MVY_W-1:0] encY;

   // Handshake qualification and the running-minimum candidate for this beat.
   // The first beat of a block always wins, so stale run values never leak
   // from one block into the next. A later beat wins only when it is strictly
   // smaller, so on a tie the earlier column is kept.
   always_comb begin
      beatAccept = in_valid && (state_q != ST_HOLD);
      firstBeat  = (state_q == ST_IDLE);
      takeBeat   = firstBeat || (sad_cmp < run_sad_q);
      closeBeat  = beatAccept && (in_last || (col_q == COL_LAST));
      outXfer    = (state_q == ST_HOLD) && out_ready;
      candSad    = takeBeat ? sad_cmp      : run_sad_q;
      candX      = takeBeat ? col_q        : run_x_q;
      candY      = takeBeat ? motion_vec_y : run_y_q;
   end

   // Convert the winning column/row into the reported motion-vector encoding.
`ifdef MV_SIGNED_EN
   always_comb begin
      encX = candX - X_CENTRE;
      encY = candY - Y_CENTRE;
   end
`else
   always_comb begin
      encX = candX;
      encY = candY;
   end
`endif

   // Next-state logic for the block FSM, column counter, running minimum and
   // result registers. The result is captured on the closing beat, and the
   // column counter is rewound there so the next block starts at column 0.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      run_sad_d   = run_sad_q;
      run_x_d     = run_x_q;
      run_y_d     = run_y_q;
      best_sad_d  = best_sad_q;
      mv_x_d      = mv_x_q;
      mv_y_d      = mv_y_q;
      col_count_d = col_count_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (beatAccept) begin
               run_sad_d = candSad;
               run_x_d   = candX;
               run_y_d   = candY;
               if (closeBeat) begin
                  state_d     = ST_HOLD;
                  col_d       = '0;
                  best_sad_d  = candSad;
                  mv_x_d      = encX;
                  mv_y_d      = encY;
                  col_count_d = col_q;
               end else begin
                  state_d = ST_ACCUM;
                  col_d   = col_q + COL_ONE;
               end
            end
         end
         ST_HOLD: begin
            if (outXfer) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            col_d   = '0;
         end
      endcase
   end

   // State registers. Reset discards any partial block and any unsent result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         run_sad_q   <= '0;
         run_x_q     <= '0;
         run_y_q     <= '0;
         best_sad_q  <= '0;
         mv_x_q      <= '0;
         mv_y_q      <= '0;
         col_count_q <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         run_sad_q   <= run_sad_d;
         run_x_q     <= run_x_d;
         run_y_q     <= run_y_d;
         best_sad_q  <= best_sad_d;
         mv_x_q      <= mv_x_d;
         mv_y_q      <= mv_y_d;
         col_count_q <= col_count_d;
      end
   end

   // Output drive. The result registers change only on a closing beat, and no
   // beat is accepted in HOLD, so the outputs stay stable under backpressure.
   always_comb begin
      in_ready  = (state_q != ST_HOLD);
      out_valid = (state_q == ST_HOLD);
      best_sad  = best_sad_q;
      mv_x      = mv_x_q;
      mv_y      = mv_y_q;
      col_count = col_count_q;
   end

endmodule

// File: tb/tb_best_mv_tracker.sv
// tb_best_mv_tracker
// Directed bench for best_mv_tracker. A small model computes the expected
// result of each block and pushes it to a scoreboard queue when the block is
// driven. A monitor pops and compares an entry on every output transfer.
// Build with MV_SIGNED_EN defined to exercise the signed motion-vector encoding.

module tb_best_mv_tracker;

   localparam int SAD_W    = 14;
   localparam int MVY_W    = 4;
   localparam int MVX_W    = 4;
   localparam int NUM_COLS = 16;

   typedef struct packed {
      logic [SAD_W-1:0] sad;
      logic [MVX_W-1:0] x;
      logic [MVY_W-1:0] y;
      logic [MVX_W-1:0] cnt;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [SAD_W-1:0] sad_cmp;
   logic [MVY_W-1:0] motion_vec_y;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [SAD_W-1:0] best_sad;
   logic [MVX_W-1:0] mv_x;
   logic [MVY_W-1:0] mv_y;
   logic [MVX_W-1:0] col_count;

   exp_t             sbQ[$];
   int               compared;
   int               mismatched;
   logic [SAD_W-1:0] sadTab [NUM_COLS];
   logic [MVY_W-1:0] rowTab [NUM_COLS];

   best_mv_tracker #(
      .SAD_W   (SAD_W),
      .MVY_W   (MVY_W),
      .MVX_W   (MVX_W),
      .NUM_COLS(NUM_COLS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sad_cmp     (sad_cmp),
      .motion_vec_y(motion_vec_y),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .best_sad    (best_sad),
      .mv_x        (mv_x),
      .mv_y        (mv_y),
      .col_count   (col_count)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so that a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected encoding of a motion vector component, computed from the raw index.
   function automatic logic [MVX_W-1:0] expX(input int c);
`ifdef MV_SIGNED_EN
      return MVX_W'(c - NUM_COLS / 2);
`else
      return MVX_W'(c);
`endif
   endfunction

   function automatic logic [MVY_W-1:0] expY(input int r);
`ifdef MV_SIGNED_EN
      return MVY_W'(r - 8);
`else
      return MVY_W'(r);
`endif
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: a transfer occurs on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL unexpected_result observed=%0d expected=none", best_sad);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            compared++;
            assert (best_sad === e.sad) else begin
               mismatched++;
               $error("[TB] FAIL best_sad observed=%0d expected=%0d", best_sad, e.sad);
            end
            compared++;
            assert (mv_x === e.x) else begin
               mismatched++;
               $error("[TB] FAIL mv_x observed=%0d expected=%0d", mv_x, e.x);
            end
            compared++;
            assert (mv_y === e.y) else begin
               mismatched++;
               $error("[TB] FAIL mv_y observed=%0d expected=%0d", mv_y, e.y);
            end
            compared++;
            assert (col_count === e.cnt) else begin
               mismatched++;
               $error("[TB] FAIL col_count observed=%0d expected=%0d", col_count, e.cnt);
            end
         end
      end
   end

   // Drive one beat. On entry we are just after a rising edge; on return we are
   // just after the edge that accepted the beat.
   task automatic driveBeat(input logic [SAD_W-1:0] s, input logic [MVY_W-1:0] r,
                            input logic last);
      int waitCycles;
      in_valid     = 1'b1;
      sad_cmp      = s;
      motion_vec_y = r;
      in_last      = last;
      waitCycles   = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waitCycles < 40) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         waitCycles++;
      end
      if (in_ready !== 1'b1) begin
         checkOutput("beat_accept_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Drive a whole block from sadTab/rowTab. The expected result is modelled
   // and queued first, then the beats are driven and the one-cycle latency is checked.
   task automatic applyStimulus(input int nBeats, input bit endWithLast);
      exp_t e;
      int   bestCol;
      bestCol = 0;
      for (int i = 1; i < nBeats; i++) begin
         if (sadTab[i] < sadTab[bestCol]) bestCol = i;
      end
      e.sad = sadTab[bestCol];
      e.x   = expX(bestCol);
      e.y   = expY(int'(rowTab[bestCol]));
      e.cnt = MVX_W'(nBeats - 1);
      sbQ.push_back(e);
      for (int i = 0; i < nBeats; i++) begin
         driveBeat(sadTab[i], rowTab[i], endWithLast && (i == nBeats - 1));
      end
      checkOutput("latency_out_valid", int'(out_valid), 1);
   endtask

   task automatic fillTab(input logic [SAD_W-1:0] s);
      for (int i = 0; i < NUM_COLS; i++) begin
         sadTab[i] = s;
         rowTab[i] = MVY_W'((i * 5 + 2) % 16);
      end
   endtask

   initial begin
      int waitCycles;
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_last      = 1'b0;
      sad_cmp      = '0;
      motion_vec_y = '0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_best_sad", int'(best_sad), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] full 16-column block, minimum at column 5");
      fillTab(14'd100);
      sadTab[5] = 14'd20;
      rowTab[5] = 4'd3;
      applyStimulus(16, 1'b0);

      $display("[TB] tie between columns 2 and 9");
      fillTab(14'd50);
      sadTab[2] = 14'd7;
      rowTab[2] = 4'd1;
      sadTab[9] = 14'd7;
      rowTab[9] = 4'd4;
      applyStimulus(16, 1'b0);

      $display("[TB] early close on in_last at column 3");
      fillTab(14'd40);
      sadTab[1] = 14'd30;
      sadTab[2] = 14'd20;
      sadTab[3] = 14'd4;
      rowTab[3] = 4'd6;
      applyStimulus(4, 1'b1);
      in_valid = 1'b1;
      sad_cmp  = 14'd1;
      checkOutput("stall_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;

      $display("[TB] output backpressure");
      out_ready = 1'b0;
      fillTab(14'd900);
      sadTab[11] = 14'd12;
      rowTab[11] = 4'd9;
      applyStimulus(16, 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         sad_cmp  = 14'd0;
         checkOutput("bp_in_ready", int'(in_ready), 0);
         checkOutput("bp_out_valid", int'(out_valid), 1);
         checkOutput("bp_best_sad", int'(best_sad), 12);
         checkOutput("bp_mv_x", int'(mv_x), int'(expX(11)));
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fillTab(14'd16383);
      applyStimulus(2, 1'b1);

      $display("[TB] reset in the middle of a block");
      fillTab(14'd300);
      sadTab[3] = 14'd2;
      for (int i = 0; i < 7; i++) begin
         driveBeat(sadTab[i], rowTab[i], 1'b0);
      end
      in_valid = 1'b1;
      sad_cmp  = 14'd1;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_best_sad", int'(best_sad), 0);
      checkOutput("rst_mv_x", int'(mv_x), 0);
      checkOutput("rst_mv_y", int'(mv_y), 0);
      checkOutput("rst_col_count", int'(col_count), 0);
      fillTab(14'd200);
      sadTab[10] = 14'd33;
      rowTab[10] = 4'd12;
      applyStimulus(16, 1'b0);

      $display("[TB] minimum at column 0, row 15");
      fillTab(14'd500);
      sadTab[0] = 14'd1;
      rowTab[0] = 4'd15;
      applyStimulus(16, 1'b0);

      waitCycles = 0;
      while (sbQ.size() != 0 && waitCycles < 50) begin
         @(posedge clk);
         waitCycles++;
      end
      checkOutput("scoreboard_drained", sbQ.size(), 0);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
